// File: rtl/instr_encoder_loader_if.sv
// Handshake and memory-write bundle for instr_encoder_loader.
//   restart, in_valid, in_ready, in_sel/rs/rt/rd/shamt/imm/target : descriptor input side
//   imem_we, imem_addr, imem_wdata                               : instruction-memory write port
//   word_count, full, err_illegal, err_sel                       : loader status
// The master modport is the descriptor source; the slave modport is the loader.
interface instr_encoder_loader_if #(
   parameter int unsigned ADDR_W = 10
);
   logic              restart;
   logic              in_valid;
   logic              in_ready;
   logic [4:0]        in_sel;
   logic [4:0]        in_rs;
   logic [4:0]        in_rt;
   logic [4:0]        in_rd;
   logic [4:0]        in_shamt;
   logic [15:0]       in_imm;
   logic [25:0]       in_target;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic [ADDR_W:0]   word_count;
   logic              full;
   logic              err_illegal;
   logic [4:0]        err_sel;

   modport master (
      output restart, in_valid, in_sel, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target,
      input  in_ready, imem_we, imem_addr, imem_wdata, word_count, full, err_illegal, err_sel
   );

   modport slave (
      input  restart, in_valid, in_sel, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target,
      output in_ready, imem_we, imem_addr, imem_wdata, word_count, full, err_illegal, err_sel
   );
endinterface

// File: rtl/instr_encoder_loader.sv
// Sequential MIPS instruction encoder and instruction-memory loader.
// Accepts one descriptor per cycle, packs it into a 32-bit MIPS word and writes it to
// consecutive word addresses, one registered stage after the accept.
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset
//   bus_io : slave side of instr_encoder_loader_if (descriptor in, imem write out, status)
module instr_encoder_loader #(
   parameter int unsigned ADDR_W = 10
) (
   input logic                    clk,
   input logic                    rst,
   instr_encoder_loader_if.slave  bus_io
);
   localparam int unsigned     DEPTH    = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [0:0] {StLoad, StFull} state_e;

   state_e            state_q;
   logic [ADDR_W:0]   count_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic              err_q;
   logic [4:0]        err_sel_q;

   logic            accept;
   logic            legal;
   logic [31:0]     enc;
   logic [ADDR_W:0] count_inc;

   // Encoder fields
   logic [5:0] op;
   logic [5:0] funct;
   logic [4:0] f_rs;
   logic [4:0] f_rt;
   logic [4:0] f_rd;
   logic [4:0] f_sh;
   logic       is_j;
   logic       is_r;

   assign bus_io.in_ready = (state_q != StFull) && !bus_io.restart && !rst;
   assign accept          = bus_io.in_valid && bus_io.in_ready;
   assign count_inc       = count_q + 1'b1;

   always_comb begin
      op    = 6'h00;
      funct = 6'h00;
      f_rs  = bus_io.in_rs;
      f_rt  = bus_io.in_rt;
      f_rd  = bus_io.in_rd;
      f_sh  = 5'd0;
      is_j  = 1'b0;
      is_r  = 1'b0;
      legal = 1'b1;
      case (bus_io.in_sel)
         5'd0:  begin is_r = 1'b1; funct = 6'h20; end
         5'd1:  begin is_r = 1'b1; funct = 6'h21; end
         5'd2:  begin is_r = 1'b1; funct = 6'h22; end
         5'd3:  begin is_r = 1'b1; funct = 6'h23; end
         5'd4:  begin is_r = 1'b1; funct = 6'h24; end
         5'd5:  begin is_r = 1'b1; funct = 6'h25; end
         5'd6:  begin is_r = 1'b1; funct = 6'h27; end
         5'd7:  begin is_r = 1'b1; funct = 6'h26; end
         5'd8:  begin is_r = 1'b1; funct = 6'h2A; end
         5'd9:  begin is_r = 1'b1; funct = 6'h2B; end
         // Shifts carry shamt and ignore rs
         5'd10: begin is_r = 1'b1; funct = 6'h00; f_rs = 5'd0; f_sh = bus_io.in_shamt; end
         5'd11: begin is_r = 1'b1; funct = 6'h02; f_rs = 5'd0; f_sh = bus_io.in_shamt; end
         // JR only carries rs
         5'd12: begin is_r = 1'b1; funct = 6'h08; f_rt = 5'd0; f_rd = 5'd0; end
         5'd13: begin is_j = 1'b1; op = 6'h02; end
         5'd14: begin is_j = 1'b1; op = 6'h03; end
         5'd15: begin op = 6'h0F; f_rs = 5'd0; end
         5'd16: op = 6'h05;
         5'd17: op = 6'h04;
         5'd18: op = 6'h2B;
         5'd19: op = 6'h23;
         5'd20: op = 6'h08;
         5'd21: op = 6'h0D;
         default: legal = 1'b0;
      endcase

      if (is_j) begin
         enc = {op, bus_io.in_target};
      end else if (is_r) begin
         enc = {op, f_rs, f_rt, f_rd, f_sh, funct};
      end else begin
         enc = {op, f_rs, f_rt, bus_io.in_imm};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StLoad;
         count_q   <= '0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         err_q     <= 1'b0;
         err_sel_q <= '0;
      end else begin
         // The write strobe is a single-cycle pulse per legal accept; a write already
         // registered drains on its own even when restart arrives.
         we_q <= 1'b0;
         if (bus_io.restart) begin
            state_q   <= StLoad;
            count_q   <= '0;
            err_q     <= 1'b0;
            err_sel_q <= '0;
         end else if (accept) begin
            if (legal) begin
               we_q    <= 1'b1;
               addr_q  <= count_q[ADDR_W-1:0];
               wdata_q <= enc;
               count_q <= count_inc;
               if (count_inc == DepthCnt) begin
                  state_q <= StFull;
               end
            end else if (!err_q) begin
               err_q     <= 1'b1;
               err_sel_q <= bus_io.in_sel;
            end
         end
      end
   end

   assign bus_io.imem_we     = we_q;
   assign bus_io.imem_addr   = addr_q;
   assign bus_io.imem_wdata  = wdata_q;
   assign bus_io.word_count  = count_q;
   assign bus_io.full        = (state_q == StFull);
   assign bus_io.err_illegal = err_q;
   assign bus_io.err_sel     = err_sel_q;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: a 1024-word instance for encoding and
// handshake scenarios and a 4-word instance for the full/restart behaviour.
module tb_instr_encoder_loader;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   instr_encoder_loader_if #(.ADDR_W(10)) bus ();
   instr_encoder_loader_if #(.ADDR_W(2))  sbus ();

   instr_encoder_loader #(.ADDR_W(10)) dut (.clk(clk), .rst(rst), .bus_io(bus.slave));
   instr_encoder_loader #(.ADDR_W(2))  dut_s (.clk(clk), .rst(rst), .bus_io(sbus.slave));

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference tables straight from the instruction list
   int unsigned op_tbl[22] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                               2, 3, 15, 5, 4, 43, 35, 8, 13};
   int unsigned fn_tbl[13] = '{32, 33, 34, 35, 36, 37, 39, 38, 42, 43, 0, 2, 8};

   logic [9:0]  q_addr[$];
   logic [31:0] q_data[$];
   int          q_cyc[$];
   logic [1:0]  sq_addr[$];
   logic [31:0] sq_data[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.imem_we === 1'b1) begin
         q_addr.push_back(bus.imem_addr);
         q_data.push_back(bus.imem_wdata);
         q_cyc.push_back(cyc);
      end
      if (sbus.imem_we === 1'b1) begin
         sq_addr.push_back(sbus.imem_addr);
         sq_data.push_back(sbus.imem_wdata);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // Returns {legal, word}
   function automatic logic [32:0] model(input logic [4:0] sel, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [4:0] sh, input logic [15:0] imm,
                                         input logic [25:0] tgt);
      int unsigned w;
      int unsigned s;
      s = int'(sel);
      if (s > 21) return {1'b0, 32'h0};
      w = op_tbl[s] << 26;
      if (s <= 12) begin
         w = w + fn_tbl[s];
         if (s != 10 && s != 11) w = w + (32'(rs) << 21);
         if (s != 12) w = w + (32'(rt) << 16) + (32'(rd) << 11);
         if (s == 10 || s == 11) w = w + (32'(sh) << 6);
      end else if (s == 13 || s == 14) begin
         w = w + 32'(tgt);
      end else begin
         if (s != 15) w = w + (32'(rs) << 21);
         w = w + (32'(rt) << 16) + 32'(imm);
      end
      return {1'b1, w};
   endfunction

   task automatic clear_queues();
      q_addr.delete();
      q_data.delete();
      q_cyc.delete();
      sq_addr.delete();
      sq_data.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.in_valid  = 1'b0;
      sbus.in_valid = 1'b0;
      bus.restart   = 1'b0;
      sbus.restart  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      clear_queues();
   endtask

   task automatic drive(input logic [4:0] sel, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                        input logic [25:0] tgt, output bit acc);
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_sel    = sel;
      bus.in_rs     = rs;
      bus.in_rt     = rt;
      bus.in_rd     = rd;
      bus.in_shamt  = sh;
      bus.in_imm    = imm;
      bus.in_target = tgt;
      #1 acc = bus.in_ready;
   endtask

   task automatic drive_s(input logic [4:0] sel, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [15:0] imm, output bit acc);
      @(negedge clk);
      sbus.in_valid  = 1'b1;
      sbus.in_sel    = sel;
      sbus.in_rs     = rs;
      sbus.in_rt     = rt;
      sbus.in_rd     = 5'd0;
      sbus.in_shamt  = 5'd0;
      sbus.in_imm    = imm;
      sbus.in_target = 26'd0;
      #1 acc = sbus.in_ready;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.in_valid  = 1'b0;
         sbus.in_valid = 1'b0;
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++; if (bus.imem_we !== 1'b0) begin errors++;
         $display("FAIL reset_we got %b want 0", bus.imem_we); end
      checks++; if (bus.imem_addr !== 10'd0) begin errors++;
         $display("FAIL reset_addr got %h want 0", bus.imem_addr); end
      checks++; if (bus.imem_wdata !== 32'd0) begin errors++;
         $display("FAIL reset_wdata got %h want 0", bus.imem_wdata); end
      checks++; if (bus.word_count !== 11'd0) begin errors++;
         $display("FAIL reset_count got %0d want 0", bus.word_count); end
      checks++; if (bus.full !== 1'b0) begin errors++;
         $display("FAIL reset_full got %b want 0", bus.full); end
      checks++; if (bus.err_illegal !== 1'b0 || bus.err_sel !== 5'd0) begin errors++;
         $display("FAIL reset_err got %b/%0d want 0/0", bus.err_illegal, bus.err_sel); end
      checks++; if (bus.in_ready !== 1'b0 || sbus.in_ready !== 1'b0) begin errors++;
         $display("FAIL reset_ready got %b/%b want 0/0", bus.in_ready, sbus.in_ready); end
      rst = 1'b0;
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++;
         $display("FAIL ready_after_reset got %b want 1", bus.in_ready); end
      clear_queues();
   endtask

   task automatic test_single_add();
      bit acc;
      do_reset();
      drive(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, acc);
      checks++; if (acc !== 1'b1) begin errors++;
         $display("FAIL add_accept got %b want 1", acc); end
      @(negedge clk);
      bus.in_valid = 1'b0;
      checks++; if (bus.imem_we !== 1'b1 || bus.imem_addr !== 10'd0) begin errors++;
         $display("FAIL add_write got we=%b addr=%0d want we=1 addr=0",
                  bus.imem_we, bus.imem_addr); end
      checks++; if (bus.imem_wdata !== 32'h00221820) begin errors++;
         $display("FAIL add_wdata got %h want 00221820", bus.imem_wdata); end
      checks++; if (bus.word_count !== 11'd1) begin errors++;
         $display("FAIL add_count got %0d want 1", bus.word_count); end
      idle(2);
   endtask

   task automatic test_back_to_back();
      bit acc;
      logic [31:0] exp[5] = '{32'h8C080004, 32'hAC080008, 32'h1022FFFF,
                              32'h0C000010, 32'h3C051234};
      do_reset();
      drive(5'd19, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0, acc);
      drive(5'd18, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0008, 26'h0, acc);
      drive(5'd17, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0, acc);
      drive(5'd14, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000010, acc);
      drive(5'd15, 5'd7, 5'd5, 5'd0, 5'd0, 16'h1234, 26'h0, acc);
      idle(3);
      checks++; if (q_addr.size() != 5) begin errors++;
         $display("FAIL b2b_count got %0d want 5", q_addr.size()); end
      else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (q_addr[i] !== 10'(i) || q_data[i] !== exp[i] || q_cyc[i] != q_cyc[0] + i)
            begin
               errors++;
               $display("FAIL b2b_word%0d got addr=%0d data=%h cyc=+%0d want %0d/%h/+%0d",
                        i, q_addr[i], q_data[i], q_cyc[i] - q_cyc[0], i, exp[i], i);
            end
         end
      end
   endtask

   task automatic test_field_mask();
      bit acc;
      do_reset();
      drive(5'd10, 5'd9, 5'd4, 5'd4, 5'd2, 16'hFFFF, 26'h3FFFFFF, acc);
      drive(5'd12, 5'd31, 5'd5, 5'd6, 5'd3, 16'hFFFF, 26'h3FFFFFF, acc);
      idle(3);
      checks++; if (q_data.size() != 2) begin errors++;
         $display("FAIL mask_count got %0d want 2", q_data.size()); end
      else begin
         checks++; if (q_data[0] !== 32'h00042080) begin errors++;
            $display("FAIL mask_sll got %h want 00042080", q_data[0]); end
         checks++; if (q_data[1] !== 32'h03E00008) begin errors++;
            $display("FAIL mask_jr got %h want 03E00008", q_data[1]); end
      end
   endtask

   task automatic test_illegal();
      bit a0, a1, a2, a3, a4;
      logic [32:0] e0, e1;
      do_reset();
      e0 = model(5'd21, 5'd3, 5'd4, 5'd0, 5'd0, 16'hBEEF, 26'h0);
      e1 = model(5'd21, 5'd5, 5'd6, 5'd0, 5'd0, 16'h0F0F, 26'h0);
      drive(5'd21, 5'd3, 5'd4, 5'd0, 5'd0, 16'hBEEF, 26'h0, a0);
      drive(5'd25, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1111, 26'h0, a1);
      drive(5'd21, 5'd5, 5'd6, 5'd0, 5'd0, 16'h0F0F, 26'h0, a2);
      idle(3);
      checks++; if ({a0, a1, a2} !== 3'b111) begin errors++;
         $display("FAIL ill_accepts got %b want 111", {a0, a1, a2}); end
      checks++;
      if (q_addr.size() != 2) begin errors++;
         $display("FAIL ill_writes got %0d want 2", q_addr.size()); end
      else if (q_addr[0] !== 10'd0 || q_addr[1] !== 10'd1 || q_data[0] !== e0[31:0] ||
               q_data[1] !== e1[31:0]) begin errors++;
         $display("FAIL ill_words got %0d:%h %0d:%h want 0:%h 1:%h",
                  q_addr[0], q_data[0], q_addr[1], q_data[1], e0[31:0], e1[31:0]); end
      checks++; if (bus.err_illegal !== 1'b1 || bus.err_sel !== 5'd25) begin errors++;
         $display("FAIL ill_err got %b/%0d want 1/25", bus.err_illegal, bus.err_sel); end
      drive(5'd30, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, a3);
      idle(2);
      checks++; if (bus.err_sel !== 5'd25 || q_addr.size() != 2) begin errors++;
         $display("FAIL ill_sticky got sel=%0d writes=%0d want 25/2",
                  bus.err_sel, q_addr.size()); end
      // Restart together with a valid descriptor: no accept, counters cleared
      @(negedge clk);
      bus.restart  = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_sel   = 5'd20;
      #1 a4 = bus.in_ready;
      @(negedge clk);
      bus.restart  = 1'b0;
      bus.in_valid = 1'b0;
      idle(2);
      checks++; if (a4 !== 1'b0 || q_addr.size() != 2) begin errors++;
         $display("FAIL restart_noaccept got ready=%b writes=%0d want 0/2", a4, q_addr.size());
      end
      checks++; if (bus.word_count !== 11'd0 || bus.err_illegal !== 1'b0 ||
                    bus.err_sel !== 5'd0) begin errors++;
         $display("FAIL restart_clear got cnt=%0d err=%b sel=%0d want 0/0/0",
                  bus.word_count, bus.err_illegal, bus.err_sel); end
   endtask

   task automatic test_full();
      bit acc;
      bit accs[6];
      logic [32:0] e;
      do_reset();
      drive_s(5'd27, 5'd0, 5'd0, 16'h0, acc);
      for (int i = 0; i < 6; i++) drive_s(5'd20, 5'(i), 5'(i + 1), 16'(i * 3), accs[i]);
      idle(3);
      for (int i = 0; i < 6; i++) begin
         checks++; if (accs[i] !== (i < 4)) begin errors++;
            $display("FAIL full_accept%0d got %b want %b", i, accs[i], i < 4); end
      end
      checks++; if (sq_addr.size() != 4) begin errors++;
         $display("FAIL full_writes got %0d want 4", sq_addr.size()); end
      else begin
         for (int i = 0; i < 4; i++) begin
            e = model(5'd20, 5'(i), 5'(i + 1), 5'd0, 5'd0, 16'(i * 3), 26'h0);
            checks++; if (sq_addr[i] !== 2'(i) || sq_data[i] !== e[31:0]) begin errors++;
               $display("FAIL full_word%0d got %0d:%h want %0d:%h",
                        i, sq_addr[i], sq_data[i], i, e[31:0]); end
         end
      end
      checks++; if (sbus.full !== 1'b1 || sbus.in_ready !== 1'b0 ||
                    sbus.word_count !== 3'd4 || sbus.err_illegal !== 1'b1) begin errors++;
         $display("FAIL full_state got full=%b rdy=%b cnt=%0d err=%b want 1/0/4/1",
                  sbus.full, sbus.in_ready, sbus.word_count, sbus.err_illegal); end
      @(negedge clk);
      sbus.restart = 1'b1;
      @(negedge clk);
      sbus.restart = 1'b0;
      #1;
      checks++; if (sbus.in_ready !== 1'b1 || sbus.full !== 1'b0 ||
                    sbus.word_count !== 3'd0 || sbus.err_illegal !== 1'b0) begin errors++;
         $display("FAIL restart_state got rdy=%b full=%b cnt=%0d err=%b want 1/0/0/0",
                  sbus.in_ready, sbus.full, sbus.word_count, sbus.err_illegal); end
      clear_queues();
      drive_s(5'd20, 5'd9, 5'd10, 16'h00AA, acc);
      idle(3);
      e = model(5'd20, 5'd9, 5'd10, 5'd0, 5'd0, 16'h00AA, 26'h0);
      checks++; if (sq_addr.size() != 1) begin errors++;
         $display("FAIL restart_write got %0d writes want 1", sq_addr.size()); end
      else if (sq_addr[0] !== 2'd0 || sq_data[0] !== e[31:0]) begin errors++;
         $display("FAIL restart_word got %0d:%h want 0:%h", sq_addr[0], sq_data[0], e[31:0]);
      end
   endtask

   task automatic test_reset_mid();
      bit acc;
      do_reset();
      drive(5'd1, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0, acc);
      @(negedge clk);
      rst = 1'b1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      checks++; if (bus.imem_we !== 1'b0 || bus.imem_addr !== 10'd0 ||
                    bus.imem_wdata !== 32'd0 || bus.word_count !== 11'd0 ||
                    bus.full !== 1'b0 || bus.in_ready !== 1'b0) begin errors++;
         $display("FAIL midrst_state got we=%b addr=%0d data=%h cnt=%0d full=%b rdy=%b want 0s",
                  bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.word_count, bus.full,
                  bus.in_ready); end
      rst = 1'b0;
      clear_queues();
      drive(5'd2, 5'd7, 5'd8, 5'd9, 5'd0, 16'h0, 26'h0, acc);
      idle(3);
      checks++; if (q_addr.size() != 1 || q_addr[0] !== 10'd0) begin errors++;
         $display("FAIL midrst_next got writes=%0d addr=%0d want 1/0",
                  q_addr.size(), (q_addr.size() > 0) ? q_addr[0] : 10'h3FF); end
   endtask

   task automatic test_random();
      bit acc;
      logic [32:0] e;
      logic [4:0]  sel, rs, rt, rd, sh;
      logic [15:0] imm;
      logic [25:0] tgt;
      logic [31:0] exp_q[$];
      bit          seen_ill;
      logic [4:0]  first_ill;
      int          bad_acc;
      do_reset();
      seen_ill  = 1'b0;
      first_ill = 5'd0;
      bad_acc   = 0;
      for (int i = 0; i < 300; i++) begin
         sel = ($urandom_range(0, 99) < 12) ? 5'($urandom_range(22, 31))
                                            : 5'($urandom_range(0, 21));
         rs  = 5'($urandom);
         rt  = 5'($urandom);
         rd  = 5'($urandom);
         sh  = 5'($urandom);
         imm = 16'($urandom);
         tgt = 26'($urandom);
         drive(sel, rs, rt, rd, sh, imm, tgt, acc);
         if (acc !== 1'b1) bad_acc++;
         e = model(sel, rs, rt, rd, sh, imm, tgt);
         if (e[32]) exp_q.push_back(e[31:0]);
         else if (!seen_ill) begin seen_ill = 1'b1; first_ill = sel; end
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      idle(3);
      checks++; if (bad_acc != 0) begin errors++;
         $display("FAIL rnd_accepts got %0d refused want 0", bad_acc); end
      checks++; if (q_data.size() != exp_q.size()) begin errors++;
         $display("FAIL rnd_count got %0d want %0d", q_data.size(), exp_q.size()); end
      else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (q_addr[i] !== 10'(i) || q_data[i] !== exp_q[i]) begin errors++;
               $display("FAIL rnd_word%0d got %0d:%h want %0d:%h",
                        i, q_addr[i], q_data[i], i, exp_q[i]); end
         end
      end
      checks++; if (bus.word_count !== 11'(exp_q.size())) begin errors++;
         $display("FAIL rnd_wordcount got %0d want %0d", bus.word_count, exp_q.size()); end
      checks++; if (bus.err_illegal !== seen_ill || bus.err_sel !== first_ill) begin errors++;
         $display("FAIL rnd_err got %b/%0d want %b/%0d",
                  bus.err_illegal, bus.err_sel, seen_ill, first_ill); end
   endtask

   initial begin
      bus.restart = 1'b0;   bus.in_valid = 1'b0;  bus.in_sel = '0;   bus.in_rs = '0;
      bus.in_rt = '0;       bus.in_rd = '0;       bus.in_shamt = '0; bus.in_imm = '0;
      bus.in_target = '0;
      sbus.restart = 1'b0;  sbus.in_valid = 1'b0; sbus.in_sel = '0;  sbus.in_rs = '0;
      sbus.in_rt = '0;      sbus.in_rd = '0;      sbus.in_shamt = '0; sbus.in_imm = '0;
      sbus.in_target = '0;
      test_reset();
      test_single_add();
      test_back_to_back();
      test_field_mask();
      test_illegal();
      test_full();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
